// File: rtl/spwtcr_rx_ds_oversampler.sv
// SpaceWire Data/Strobe receiver: oversamples D/S on clk_sys, recovers bits from D^S edges
// and deserialises them into WORD_W-bit words. Optional macro RX_RATE_MEAS_EN adds bit_period.
module spwtcr_rx_ds_oversampler #(
    parameter int SYNC_STAGES  = 2,
    parameter int WORD_W       = 2,
    parameter int DISC_TIMEOUT = 85
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              Din,
    input  logic              Sin,
    input  logic              rx_enable,
    output logic [WORD_W-1:0] bit_word,
    output logic              bit_valid,
    output logic              got_bit,
    output logic              disconnect,
    output logic              ds_error,
    output logic              clk_rx
`ifdef RX_RATE_MEAS_EN
    ,
    output logic [15:0]       bit_period
`endif
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int TO_W  = $clog2(DISC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WORD_FULL = CNT_W'(WORD_W);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(DISC_TIMEOUT);

    typedef enum logic [1:0] {
        DISABLED,
        WAIT_FIRST,
        RUN,
        DISCONNECTED
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] d_sync_reg, s_sync_reg;
    logic [SYNC_STAGES-1:0] d_sync_next, s_sync_next;
    logic                   d_p_reg, s_p_reg;
    logic                   d_s, s_s;
    logic                   d_chg, s_chg, valid_tr, both_tr;
    logic                   timeout_hit, active, shift_en, err_en;
    logic [WORD_W-1:0]      sr_reg, sr_next;
    logic [CNT_W-1:0]       bit_cnt_reg, cnt_base;
    logic [TO_W-1:0]        to_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign d_sync_next[gi] = Din;
                assign s_sync_next[gi] = Sin;
            end else begin : g_rest
                assign d_sync_next[gi] = d_sync_reg[gi-1];
                assign s_sync_next[gi] = s_sync_reg[gi-1];
            end
        end

        // New bits enter at the top so the first bit of a word lands in bit 0.
        if (WORD_W == 1) begin : g_sr_single
            assign sr_next = d_s;
        end else begin : g_sr_multi
            assign sr_next = {d_s, sr_reg[WORD_W-1:1]};
        end
    endgenerate

    assign d_s      = d_sync_reg[SYNC_STAGES-1];
    assign s_s      = s_sync_reg[SYNC_STAGES-1];
    assign d_chg    = (d_s != d_p_reg);
    assign s_chg    = (s_s != s_p_reg);
    assign valid_tr = d_chg ^ s_chg;
    assign both_tr  = d_chg & s_chg;

    assign timeout_hit = (state_reg == RUN) && (to_cnt_reg == TO_LIMIT);
    assign active      = rx_enable &&
                         ((state_reg == WAIT_FIRST) || ((state_reg == RUN) && !timeout_hit));
    assign shift_en    = active && valid_tr;
    assign err_en      = active && both_tr;
    assign cnt_base    = (bit_cnt_reg == WORD_FULL) ? '0 : bit_cnt_reg;

    always_comb begin
        state_next = state_reg;
        if (!rx_enable) begin
            state_next = DISABLED;
        end else begin
            case (state_reg)
                DISABLED:     state_next = WAIT_FIRST;
                WAIT_FIRST:   if (valid_tr) state_next = RUN;
                RUN:          if (timeout_hit) state_next = DISCONNECTED;
                DISCONNECTED: state_next = DISCONNECTED;
                default:      state_next = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_reg <= DISABLED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            d_sync_reg  <= '0;
            s_sync_reg  <= '0;
            d_p_reg     <= 1'b0;
            s_p_reg     <= 1'b0;
            clk_rx      <= 1'b0;
            ds_error    <= 1'b0;
            bit_valid   <= 1'b0;
            bit_word    <= '0;
            got_bit     <= 1'b0;
            disconnect  <= 1'b0;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else begin
            d_sync_reg <= d_sync_next;
            s_sync_reg <= s_sync_next;
            d_p_reg    <= d_s;
            s_p_reg    <= s_s;
            clk_rx     <= d_s ^ s_s;
            ds_error   <= err_en;
            bit_valid  <= 1'b0;

            if (!rx_enable || (state_reg == DISABLED)) begin
                got_bit     <= 1'b0;
                disconnect  <= 1'b0;
                sr_reg      <= '0;
                bit_cnt_reg <= '0;
                to_cnt_reg  <= '0;
            end else begin
                if (shift_en) begin
                    sr_reg  <= sr_next;
                    got_bit <= 1'b1;
                end
                bit_cnt_reg <= cnt_base + CNT_W'(shift_en);

                // A full count means the word completed on the previous edge.
                if ((state_reg == RUN) && (bit_cnt_reg == WORD_FULL)) begin
                    bit_word  <= sr_reg;
                    bit_valid <= 1'b1;
                end

                if (state_reg == RUN) begin
                    if (valid_tr || both_tr) begin
                        to_cnt_reg <= '0;
                    end else if (!timeout_hit) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                if (timeout_hit) begin
                    disconnect <= 1'b1;
                end
            end
        end
    end

`ifdef RX_RATE_MEAS_EN
    logic [15:0] per_cnt_reg;
    logic [15:0] per_inc;

    assign per_inc = (per_cnt_reg == 16'hFFFF) ? 16'hFFFF : per_cnt_reg + 16'd1;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            per_cnt_reg <= '0;
            bit_period  <= '0;
        end else if (!rx_enable || (state_reg == DISABLED)) begin
            per_cnt_reg <= '0;
            bit_period  <= '0;
        end else if (active) begin
            if (valid_tr) begin
                per_cnt_reg <= '0;
                // The transition that leaves WAIT_FIRST has no predecessor to measure against.
                if (state_reg == RUN) begin
                    bit_period <= per_inc;
                end
            end else if (state_reg == RUN) begin
                per_cnt_reg <= per_inc;
            end
        end
    end
`endif

endmodule

// File: doc/spwtcr_rx_ds_oversampler.md
Name: spwtcr_rx_ds_oversampler

Overview:
Parametrised successor to the combinational D xor S receive clock recovery. Samples SpaceWire Data/Strobe on one system clock and resynchronises them. Detects each bit from the D^S transition and deserialises bits into WORD_W-bit words with a valid strobe. Also flags first-bit arrival, disconnect timeout and simultaneous D/S toggles. Sits between the LVDS input pins and the receive character decoder.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the Din/Sin synchroniser (legal range 2..4).
WORD_W, 2, bits per output word (legal range 1..16).
DISC_TIMEOUT, 85, consecutive transition-free clk_sys cycles in RUN that declare a disconnect (legal range 2..65535).

Ports:
clk_sys  in  1  system clock; must be faster than the link bit rate.
rst_sys  in  1  synchronous, active-high reset.
Din  in  1  SpaceWire Data, asynchronous.
Sin  in  1  SpaceWire Strobe, asynchronous.
rx_enable  in  1  receiver enable; low forces the DISABLED state.
bit_word  out  WORD_W  deserialised bits; first received bit in bit 0.
bit_valid  out  1  one-cycle strobe; bit_word is valid in that cycle.
got_bit  out  1  level; high once the first transition is detected.
disconnect  out  1  level, sticky until rx_enable is low or reset.
ds_error  out  1  one-cycle pulse when D and S toggle in the same sample.
clk_rx  out  1  synchronised D^S level, for debug and compatibility.

Behaviour:
- Reset values: all outputs 0, all synchroniser stages 0, state DISABLED, counters 0.
- Synchroniser: Din and Sin each pass through SYNC_STAGES registers, giving d_s and s_s. Registers d_p and s_p hold the previous d_s and s_s.
- Transitions:
  - A valid transition occurs when exactly one of (d_s!=d_p) or (s_s!=s_p) is true.
  - When both are true, ds_error pulses for that cycle, no bit is shifted and the bit counter is unchanged.
- clk_rx = d_s ^ s_s, registered.
- State DISABLED:
  - Shift register, bit counter and timeout counter are held at 0.
  - got_bit = 0, disconnect = 0.
  - Moves to WAIT_FIRST when rx_enable = 1.
- State WAIT_FIRST:
  - The first valid transition sets got_bit = 1, shifts in d_s as bit 0 and moves to RUN.
  - No timeout applies in this state.
- State RUN:
  - Each valid transition shifts d_s in (LSB-first fill), increments the bit counter and clears the timeout counter.
  - When the bit counter reaches WORD_W, bit_word is registered and bit_valid = 1 in the next cycle. The counter wraps to 0 in the same cycle.
  - Back-to-back words are allowed; bit_valid can pulse every WORD_W transitions with no gap cycle.
  - The timeout counter increments on every cycle without a valid transition. A ds_error cycle counts as activity.
  - When the count reaches DISC_TIMEOUT, disconnect = 1 from the next cycle and the state moves to DISCONNECTED.
  - A partial word is discarded and bit_valid is not raised.
- State DISCONNECTED:
  - disconnect holds 1 and transitions are ignored.
  - Leaves only when rx_enable = 0, going to DISABLED.
- rx_enable falling in any state moves to DISABLED on the next edge. A partial word is discarded.
- rst_sys mid-operation returns every register to its reset value on the next edge, regardless of rx_enable.
- Latency: pin change → valid transition detected SYNC_STAGES+1 cycles later → bit_valid one cycle after the WORD_W-th detection.
- Counter width is $clog2(DISC_TIMEOUT+1); it saturates and never wraps.

Optional Feature:
Macro RX_RATE_MEAS_EN.
- With the macro defined: adds output port bit_period (16 bits, reset 0).
  - A 16-bit cycle counter runs in RUN and clears on each valid transition.
  - On each valid transition after the first, bit_period is loaded with the cycle count since the previous transition.
  - The counter saturates at 16'hFFFF.
  - bit_period holds its value in DISCONNECTED and clears in DISABLED.
- Without the macro: no bit_period port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset and idle: rst_sys = 1 for 3 cycles with rx_enable = 0 → all outputs 0; pin toggles produce no bit_valid and no got_bit.
- Word deserialisation: WORD_W = 2, rx_enable = 1, drive bits 1,0,1,1 with 10 clk_sys per bit → got_bit rises at the first detection; bit_valid pulses twice with bit_word = 2'b01 then 2'b11; first pulse appears SYNC_STAGES+2 cycles after the 2nd pin change.
- Disconnect: after 4 bits, hold pins static for DISC_TIMEOUT = 85 cycles → disconnect = 1 exactly in cycle 86; later toggles produce no bit_valid.
- Recovery: from DISCONNECTED, set rx_enable = 0 for 1 cycle then 1 → disconnect = 0 and got_bit = 0; a new bit stream is decoded from bit 0.
- Simultaneous toggle: flip Din and Sin in the same cycle mid-stream → ds_error pulses for one cycle; bit counter is unchanged and the next word contains only valid bits.
- With RX_RATE_MEAS_EN: bits spaced 7 clk_sys apart → bit_period = 7 after the 2nd transition; after reset → bit_period = 0.
